// File: rtl/z80_mon_pkg.sv
// Shared types for the Z80 bus monitor: cycle kinds, sampled pin bundle, trace record
// and the start-condition decoder.
package z80_mon_pkg;

  localparam int unsigned StampW = 16;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    MEMRD = 3'd1,
    MEMWR = 3'd2,
    IORD  = 3'd3,
    IOWR  = 3'd4,
    INTA  = 3'd5,
    ERR   = 3'd7
  } kind_e;

  typedef struct packed {
    logic        nm1;
    logic        nmreq;
    logic        niorq;
    logic        nrd;
    logic        nwr;
    logic        nrfsh;
    logic [15:0] a;
    logic [7:0]  d;
  } pins_t;

  typedef struct packed {
    kind_e              kind;
    logic [15:0]        addr;
    logic [7:0]         data;
    logic [StampW-1:0]  stamp;
  } mon_rec_t;

  typedef struct packed {
    logic  hit;
    kind_e kind;
  } decode_t;

  localparam pins_t PinsIdle = '{nm1: 1'b1, nmreq: 1'b1, niorq: 1'b1, nrd: 1'b1, nwr: 1'b1,
                                 nrfsh: 1'b1, a: 16'h0000, d: 8'h00};

  // Refresh is masked first; conflicting strobes win over every well-formed kind.
  function automatic decode_t decode_start(pins_t p);
    decode_t r;
    r.hit  = 1'b1;
    r.kind = FETCH;
    if (!p.nrfsh && !p.nmreq) begin
      r.hit = 1'b0;
    end else if (!p.nrd && !p.nwr && (!p.nmreq || !p.niorq)) begin
      r.kind = ERR;
    end else if (!p.nmreq && !p.nrd) begin
      r.kind = p.nm1 ? MEMRD : FETCH;
    end else if (!p.nmreq && !p.nwr) begin
      r.kind = MEMWR;
    end else if (!p.niorq && !p.nrd) begin
      r.kind = IORD;
    end else if (!p.niorq && !p.nwr) begin
      r.kind = IOWR;
    end else if (!p.nm1 && !p.niorq) begin
      r.kind = INTA;
    end else begin
      r.hit = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mon_fifo.sv
// First-word fall-through record FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module mon_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         rec_t = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  rec_t                   push_rec,
  input  logic                   pop,
  output logic                   valid,
  output rec_t                   head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  rec_t        mem [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        full, do_pop, do_push;

  assign valid   = (wr_q != rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && valid;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_q[AW-1:0]];
  assign level   = wr_q - rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrOne;
      if (do_pop)  rd_q <= rd_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= push_rec;
  end

endmodule

// File: rtl/z80_bus_monitor.sv
// Passive Z80 bus observer: registers the pins once, tracks each bus cycle with a
// two-state FSM and queues one timestamped record per completed cycle.
module z80_bus_monitor
  import z80_mon_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned STAMP_W = StampW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   nM1,
  input  logic                   nMREQ,
  input  logic                   nIORQ,
  input  logic                   nRD,
  input  logic                   nWR,
  input  logic                   nRFSH,
  input  logic [15:0]            A,
  input  logic [7:0]             D,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_kind,
  output logic [15:0]            out_addr,
  output logic [7:0]             out_data,
  output logic [STAMP_W-1:0]     out_stamp,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam logic StIdle   = 1'b0;
  localparam logic StActive = 1'b1;
  localparam logic [STAMP_W-1:0] StampOne = 1;

  pins_t              s_q;
  logic               state_q, state_d;
  logic [STAMP_W-1:0] stamp_q;
  kind_e              kind_q;
  logic [15:0]        addr_q;
  logic [7:0]         data_q;
  logic [STAMP_W-1:0] cstamp_q;
  logic               overflow_q;

  decode_t  dec;
  logic     cyc_end, start, finish, fifo_drop;
  mon_rec_t push_rec, head;

  assign dec     = decode_start(s_q);
  // An interrupt acknowledge never asserts nRD/nWR, so it is closed by nIORQ instead.
  assign cyc_end = (kind_q == INTA) ? s_q.niorq : (s_q.nrd && s_q.nwr);
  assign start   = (state_q == StIdle) && enable && dec.hit;
  assign finish  = (state_q == StActive) && cyc_end;

  assign push_rec = '{kind: kind_q, addr: addr_q, data: data_q, stamp: StampW'(cstamp_q)};

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (start)   state_d = StActive;
      StActive: if (cyc_end) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q      <= PinsIdle;
      state_q  <= StIdle;
      stamp_q  <= '0;
      kind_q   <= FETCH;
      addr_q   <= '0;
      data_q   <= '0;
      cstamp_q <= '0;
    end else begin
      s_q     <= '{nm1: nM1, nmreq: nMREQ, niorq: nIORQ, nrd: nRD, nwr: nWR, nrfsh: nRFSH,
                   a: A, d: D};
      stamp_q <= stamp_q + StampOne;
      state_q <= state_d;
      if (start) begin
        kind_q   <= dec.kind;
        addr_q   <= s_q.a;
        data_q   <= s_q.d;
        cstamp_q <= stamp_q;
      end else if ((state_q == StActive) && !cyc_end) begin
        data_q <= s_q.d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (fifo_drop) begin
      overflow_q <= 1'b1;
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  mon_fifo #(
    .DEPTH (DEPTH),
    .rec_t (mon_rec_t)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (finish),
    .push_rec (push_rec),
    .pop      (out_ready),
    .valid    (out_valid),
    .head     (head),
    .level    (level),
    .drop     (fifo_drop)
  );

  assign overflow  = overflow_q;
  assign out_kind  = out_valid ? head.kind : 3'd0;
  assign out_addr  = out_valid ? head.addr : 16'h0000;
  assign out_data  = out_valid ? head.data : 8'h00;
  assign out_stamp = out_valid ? STAMP_W'(head.stamp) : '0;

endmodule

// File: tb/tb_z80_bus_monitor.sv
// Directed and randomized bus cycles checked against a transaction-level model of the
// monitor's record queue.
module tb_z80_bus_monitor;

  localparam int DEPTH = 8;
  localparam int KFetch = 0, KMemRd = 1, KMemWr = 2, KIoRd = 3, KIoWr = 4, KInta = 5,
                 KErr = 7, KIdle = -1;

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [7:0]  d;
    logic [15:0] st;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
  logic [15:0] A;
  logic [7:0]  D;
  logic        out_valid, out_ready;
  logic [2:0]  out_kind;
  logic [15:0] out_addr;
  logic [7:0]  out_data;
  logic [15:0] out_stamp;
  logic [3:0]  level;
  logic        overflow, clr_ovf;

  int          passed = 0, fails = 0, total = 0;
  exp_t        mq[$];
  logic        m_ovf = 1'b0;
  logic [15:0] ctr = 16'h0;
  bit          push_now = 0;
  exp_t        push_rec;
  int          rdy_mode = 0;
  bit          pop_at_push = 0, clr_at_push = 0;

  always #5 clk = ~clk;

  z80_bus_monitor #(
    .DEPTH   (DEPTH),
    .STAMP_W (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .nM1       (nM1),
    .nMREQ     (nMREQ),
    .nIORQ     (nIORQ),
    .nRD       (nRD),
    .nWR       (nWR),
    .nRFSH     (nRFSH),
    .A         (A),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_stamp (out_stamp),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic step();
    bit pop, drop;
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("level", 32'(level), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) begin
      chk("out_kind", 32'(out_kind), 32'(mq[0].kind));
      chk("out_addr", 32'(out_addr), 32'(mq[0].a));
      chk("out_data", 32'(out_data), 32'(mq[0].d));
      chk("out_stamp", 32'(out_stamp), 32'(mq[0].st));
    end
    pop = out_ready && (mq.size() != 0);
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      ctr   = 16'h0;
    end else begin
      ctr  = ctr + 16'h1;
      if (pop) void'(mq.pop_front());
      drop = 0;
      if (push_now) begin
        if (mq.size() < DEPTH) mq.push_back(push_rec);
        else drop = 1;
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
    push_now = 0;
    #1;
    if (rdy_mode == 2) out_ready = 1'($urandom);
  endtask

  task automatic set_ctrl(input int k);
    {nM1, nMREQ, nIORQ, nRD, nWR, nRFSH} = 6'b111111;
    case (k)
      KFetch:  {nM1, nMREQ, nRD} = 3'b000;
      KMemRd:  {nMREQ, nRD} = 2'b00;
      KMemWr:  {nMREQ, nWR} = 2'b00;
      KIoRd:   {nIORQ, nRD} = 2'b00;
      KIoWr:   {nIORQ, nWR} = 2'b00;
      KInta:   {nM1, nIORQ} = 2'b00;
      KErr:    {nMREQ, nRD, nWR} = 3'b000;
      default: ;
    endcase
  endtask

  // Strobes held for len clocks; only the final data beat is the real value.
  task automatic bus_cycle(input int k, input logic [15:0] a, input logic [7:0] d,
                           input int len, input bit drop_en);
    exp_t r;
    bit   started = 0;
    set_ctrl(k);
    A = a;
    for (int i = 0; i < len; i++) begin
      D = (i == len - 1) ? d : 8'($urandom);
      if (i == 1) started = enable;
      step();
      if (i == 0) r.st = ctr;
      if (i == 1 && drop_en) enable = 1'b0;
    end
    if (len == 1) started = enable;
    set_ctrl(KIdle);
    D = 8'($urandom);
    step();
    r.kind = k;
    r.a    = a;
    r.d    = d;
    if (pop_at_push) out_ready = 1'b1;
    if (clr_at_push) clr_ovf = 1'b1;
    push_now = started;
    push_rec = r;
    step();
    if (pop_at_push) out_ready = (rdy_mode == 1);
    clr_ovf = 1'b0;
  endtask

  task automatic idle(input int n, input bit rfsh);
    for (int i = 0; i < n; i++) begin
      set_ctrl(KIdle);
      if (rfsh) {nMREQ, nRFSH} = 2'b00;
      step();
    end
    set_ctrl(KIdle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int kinds[7] = '{KFetch, KMemRd, KMemWr, KIoRd, KIoWr, KInta, KErr};
    reset = 1'b1; enable = 1'b1; out_ready = 1'b0; clr_ovf = 1'b0;
    set_ctrl(KIdle); A = 16'h0; D = 8'h0;
    @(posedge clk); #1;
    step(); step();
    chk("rst_kind", 32'(out_kind), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_stamp", 32'(out_stamp), 32'd0);
    reset = 1'b0;

    // MEMRD right after reset, then drain it.
    bus_cycle(KMemRd, 16'h1234, 8'hA5, 3, 0);
    chk("memrd_stamp_abs", 32'(out_stamp), 32'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Fetch, refresh, write back-to-back.
    bus_cycle(KFetch, 16'h0000, 8'h3E, 2, 0);
    idle(2, 1);
    bus_cycle(KMemWr, 16'h8000, 8'h42, 2, 0);
    bus_cycle(KIoWr, 16'h10FE, 8'h07, 3, 0);
    bus_cycle(KInta, 16'h00AB, 8'hFF, 3, 0);
    bus_cycle(KErr, 16'h5555, 8'h99, 2, 0);
    bus_cycle(KIoRd, 16'h00FE, 8'h5A, 1, 0);
    // enable low before start, then dropped mid-cycle.
    enable = 1'b0;
    bus_cycle(KMemRd, 16'hDEAD, 8'h11, 2, 0);
    enable = 1'b1;
    bus_cycle(KMemRd, 16'hBEEF, 8'h22, 4, 1);
    enable = 1'b1;
    rdy_mode = 1; out_ready = 1'b1;
    idle(DEPTH, 0);

    // Overflow with the consumer stalled.
    rdy_mode = 0; out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) bus_cycle(KMemRd, 16'(16'h4000 + i), 8'(i), 2, 0);
    chk("ovf_level", 32'(level), DEPTH);
    chk("ovf_flag", 32'(overflow), 32'd1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    pop_at_push = 1;
    bus_cycle(KMemWr, 16'h7777, 8'h77, 2, 0);
    pop_at_push = 0;
    chk("full_pushpop_level", 32'(level), DEPTH);
    chk("full_pushpop_ovf", 32'(overflow), 32'd0);
    clr_at_push = 1;
    bus_cycle(KMemWr, 16'h6666, 8'h66, 2, 0);
    clr_at_push = 0;
    chk("set_beats_clr", 32'(overflow), 32'd1);
    rdy_mode = 1; out_ready = 1'b1;
    idle(DEPTH + 1, 0);

    // Reset in the middle of an active read.
    rdy_mode = 0; out_ready = 1'b0;
    set_ctrl(KMemRd); A = 16'h3333; D = 8'h33;
    step(); step(); step();
    reset = 1'b1; set_ctrl(KIdle);
    step();
    reset = 1'b0;
    step(); step();
    chk("rst_mid_level", 32'(level), 32'd0);
    bus_cycle(KMemRd, 16'h2222, 8'h44, 2, 0);
    chk("rst_mid_stamp", 32'(out_stamp), 32'd3);
    rdy_mode = 1; out_ready = 1'b1;
    idle(2, 0);

    // Randomized traffic with a random consumer.
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      int len;
      bit dr;
      len = $urandom_range(1, 4);
      dr  = (len >= 2) && ($urandom_range(0, 5) == 0);
      enable = ($urandom_range(0, 7) != 0);
      bus_cycle(kinds[$urandom_range(0, 6)], 16'($urandom), 8'($urandom), len, dr);
      enable = 1'b1;
      if ($urandom_range(0, 3) == 0) clr_ovf = 1'b1;
      idle($urandom_range(0, 2), 1'($urandom));
      clr_ovf = 1'b0;
    end
    rdy_mode = 1; out_ready = 1'b1;
    idle(DEPTH + 2, 0);
    chk("final_level", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
